// File: rtl/exception_pkg.sv
// Shared exception definitions: sequencer state, request kind, cause codes
// and the fixed exception entry vector.
package exception_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_REDIRECT = 2'd3
  } exc_ctrl_state_t;

  typedef enum logic {
    EXC  = 1'b0,
    ERET = 1'b1
  } exc_kind_t;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_t;

  localparam logic [31:0] EXC_ENTRY = 32'hBFC0_0380;

  // Only address-error exceptions carry a meaningful faulting address.
  function automatic logic has_badvaddr(input exc_code_t code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

  // A delay-slot instruction restarts at its branch, one word earlier.
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/exc_redirect_ctrl.sv
// Exception / ERET sequencer: capture the request, drain the data bus,
// commit the CP0 update for one cycle, then hold the fetch redirect
// until it is accepted. Owns pipeline flush and stall for the sequence.
module exc_redirect_ctrl
  import exception_pkg::*;
#(
  parameter logic [31:0] EXC_ENTRY = exception_pkg::EXC_ENTRY,
  parameter int unsigned DRAIN_MAX = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_valid,
  input  exc_code_t   exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_in_delay_slot,
  input  logic [31:0] exc_badvaddr,
  input  logic        is_eret,
  input  logic [31:0] cp0_epc,
  input  logic        mem_pending,
  input  logic        redirect_ready,
  output logic        busy,
  output logic        flush,
  output logic        cp0_exc_we,
  output logic [31:0] cp0_epc_wdata,
  output logic [4:0]  cp0_exccode,
  output logic        cp0_bd,
  output logic        cp0_badvaddr_we,
  output logic [31:0] cp0_badvaddr,
  output logic        cp0_eret_clr,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        drain_timeout
);

  // The counter is 8 bits wide, so a larger limit is clamped to 255.
  localparam logic [7:0] DRAIN_LIM = (DRAIN_MAX > 255) ? 8'd255 : 8'(DRAIN_MAX);

  exc_ctrl_state_t state;
  exc_kind_t       kind_q;
  exc_code_t       code_q;
  logic [7:0]      cnt;
  logic [31:0]     epc_q;
  logic            bd_q;
  logic [31:0]     bva_q;
  logic [31:0]     target_q;
  logic            busy_q;
  logic            timeout_q;
  logic            drain_last;

  // Last permitted DRAIN cycle: the counter is about to reach the limit.
  assign drain_last = (({1'b0, cnt} + 9'd1) >= {1'b0, DRAIN_LIM});

  // Sequencer state, drain counter and captured request fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      kind_q    <= EXC;
      code_q    <= EXC_INT;
      cnt       <= 8'd0;
      epc_q     <= 32'd0;
      bd_q      <= 1'b0;
      bva_q     <= 32'd0;
      target_q  <= 32'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (exc_valid || is_eret) begin
            busy_q <= 1'b1;
            cnt    <= 8'd0;
            state  <= mem_pending ? ST_DRAIN : ST_COMMIT;
            // An exception presented alongside an ERET takes priority.
            if (exc_valid) begin
              kind_q   <= EXC;
              code_q   <= exc_code;
              epc_q    <= epc_of(exc_pc, exc_in_delay_slot);
              bd_q     <= exc_in_delay_slot;
              bva_q    <= exc_badvaddr;
              target_q <= EXC_ENTRY;
            end else begin
              kind_q   <= ERET;
              code_q   <= EXC_INT;
              epc_q    <= 32'd0;
              bd_q     <= 1'b0;
              bva_q    <= 32'd0;
              target_q <= cp0_epc;
            end
          end
        end
        ST_DRAIN: begin
          if (cnt != DRAIN_LIM) begin
            cnt <= cnt + 8'd1;
          end
          if (!mem_pending) begin
            state <= ST_COMMIT;
          end else if (drain_last) begin
            state     <= ST_COMMIT;
            timeout_q <= 1'b1;
          end
        end
        ST_COMMIT: begin
          state <= ST_REDIRECT;
        end
        ST_REDIRECT: begin
          if (redirect_ready) begin
            state    <= ST_IDLE;
            busy_q   <= 1'b0;
            kind_q   <= EXC;
            code_q   <= EXC_INT;
            epc_q    <= 32'd0;
            bd_q     <= 1'b0;
            bva_q    <= 32'd0;
            target_q <= 32'd0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Output decode: flush, CP0 commit pulses and the held redirect.
  always_comb begin
    busy            = busy_q;
    drain_timeout   = timeout_q;
    flush           = (state != ST_IDLE) || exc_valid || is_eret;
    cp0_exc_we      = 1'b0;
    cp0_epc_wdata   = 32'd0;
    cp0_exccode     = 5'd0;
    cp0_bd          = 1'b0;
    cp0_badvaddr_we = 1'b0;
    cp0_badvaddr    = 32'd0;
    cp0_eret_clr    = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'd0;
    if (state == ST_COMMIT) begin
      if (kind_q == EXC) begin
        cp0_exc_we    = 1'b1;
        cp0_epc_wdata = epc_q;
        cp0_exccode   = code_q;
        cp0_bd        = bd_q;
        if (has_badvaddr(code_q)) begin
          cp0_badvaddr_we = 1'b1;
          cp0_badvaddr    = bva_q;
        end
      end else begin
        cp0_eret_clr = 1'b1;
      end
    end
    if (state == ST_REDIRECT) begin
      redirect_valid = 1'b1;
      redirect_pc    = target_q;
    end
  end

endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// Bench for exc_redirect_ctrl: directed requests, expected CP0 commits and
// redirect acceptances queued at issue time and checked by a monitor.
module tb_exc_redirect_ctrl;
  import exception_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_valid;
  exc_code_t   exc_code;
  logic [31:0] exc_pc;
  logic        exc_in_delay_slot;
  logic [31:0] exc_badvaddr;
  logic        is_eret;
  logic [31:0] cp0_epc;
  logic        mem_pending;
  logic        redirect_ready;

  logic        busy, flush, cp0_exc_we, cp0_bd, cp0_badvaddr_we, cp0_eret_clr;
  logic        redirect_valid, drain_timeout;
  logic [31:0] cp0_epc_wdata, cp0_badvaddr, redirect_pc;
  logic [4:0]  cp0_exccode;

  logic        busy_4, flush_4, cp0_exc_we_4, cp0_bd_4, cp0_badvaddr_we_4, cp0_eret_clr_4;
  logic        redirect_valid_4, drain_timeout_4;
  logic [31:0] cp0_epc_wdata_4, cp0_badvaddr_4, redirect_pc_4;
  logic [4:0]  cp0_exccode_4;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int          cyc;
    int          ev;
    logic [31:0] epc;
    logic [4:0]  code;
    logic        bd;
    logic        bva_we;
    logic [31:0] bva;
    logic [31:0] rpc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   mon_ev;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  exc_redirect_ctrl dut (
    .clk(clk), .reset(reset), .exc_valid(exc_valid), .exc_code(exc_code),
    .exc_pc(exc_pc), .exc_in_delay_slot(exc_in_delay_slot),
    .exc_badvaddr(exc_badvaddr), .is_eret(is_eret), .cp0_epc(cp0_epc),
    .mem_pending(mem_pending), .redirect_ready(redirect_ready),
    .busy(busy), .flush(flush), .cp0_exc_we(cp0_exc_we),
    .cp0_epc_wdata(cp0_epc_wdata), .cp0_exccode(cp0_exccode), .cp0_bd(cp0_bd),
    .cp0_badvaddr_we(cp0_badvaddr_we), .cp0_badvaddr(cp0_badvaddr),
    .cp0_eret_clr(cp0_eret_clr), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .drain_timeout(drain_timeout)
  );

  exc_redirect_ctrl #(.DRAIN_MAX(4)) dut4 (
    .clk(clk), .reset(reset), .exc_valid(exc_valid), .exc_code(exc_code),
    .exc_pc(exc_pc), .exc_in_delay_slot(exc_in_delay_slot),
    .exc_badvaddr(exc_badvaddr), .is_eret(is_eret), .cp0_epc(cp0_epc),
    .mem_pending(mem_pending), .redirect_ready(redirect_ready),
    .busy(busy_4), .flush(flush_4), .cp0_exc_we(cp0_exc_we_4),
    .cp0_epc_wdata(cp0_epc_wdata_4), .cp0_exccode(cp0_exccode_4), .cp0_bd(cp0_bd_4),
    .cp0_badvaddr_we(cp0_badvaddr_we_4), .cp0_badvaddr(cp0_badvaddr_4),
    .cp0_eret_clr(cp0_eret_clr_4), .redirect_valid(redirect_valid_4),
    .redirect_pc(redirect_pc_4), .drain_timeout(drain_timeout_4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exc(input int c, input logic [31:0] epc, input logic [4:0] code,
                          input logic bd, input logic bwe, input logic [31:0] bva);
    sb.push_back('{c, 0, epc, code, bd, bwe, bva, 32'd0});
  endtask

  task automatic push_eret(input int c);
    sb.push_back('{c, 1, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0});
  endtask

  task automatic push_rdr(input int c, input logic [31:0] rpc);
    sb.push_back('{c, 2, 32'd0, 5'd0, 1'b0, 1'b0, 32'd0, rpc});
  endtask

  // Monitor: every CP0 commit pulse or accepted redirect consumes one entry.
  always @(negedge clk) begin
    if (!reset && (cp0_exc_we || cp0_eret_clr || (redirect_valid && redirect_ready))) begin
      mon_ev = cp0_exc_we ? 0 : (cp0_eret_clr ? 1 : 2);
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: event %0d at cycle %0d, none expected", mon_ev, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("event_kind", 32'(mon_ev), 32'(mon_e.ev));
        chk("event_cycle", 32'(cyc), 32'(mon_e.cyc));
        case (mon_e.ev)
          0: begin
            chk("cp0_epc_wdata", cp0_epc_wdata, mon_e.epc);
            chk("cp0_exccode", 32'(cp0_exccode), 32'(mon_e.code));
            chk("cp0_bd", 32'(cp0_bd), 32'(mon_e.bd));
            chk("cp0_badvaddr_we", 32'(cp0_badvaddr_we), 32'(mon_e.bva_we));
            chk("cp0_badvaddr", cp0_badvaddr, mon_e.bva);
            chk("eret_clr_during_exc", 32'(cp0_eret_clr), 32'd0);
          end
          1: begin
            chk("exc_we_during_eret", 32'(cp0_exc_we), 32'd0);
            chk("badvaddr_we_during_eret", 32'(cp0_badvaddr_we), 32'd0);
            chk("epc_wdata_during_eret", cp0_epc_wdata, 32'd0);
          end
          default: begin
            chk("redirect_pc", redirect_pc, mon_e.rpc);
          end
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_flush"}, 32'(flush), 32'd0);
    chk({tag, "_exc_we"}, 32'(cp0_exc_we), 32'd0);
    chk({tag, "_epc_wdata"}, cp0_epc_wdata, 32'd0);
    chk({tag, "_badvaddr_we"}, 32'(cp0_badvaddr_we), 32'd0);
    chk({tag, "_eret_clr"}, 32'(cp0_eret_clr), 32'd0);
    chk({tag, "_redirect_valid"}, 32'(redirect_valid), 32'd0);
    chk({tag, "_redirect_pc"}, redirect_pc, 32'd0);
    chk({tag, "_drain_timeout"}, 32'(drain_timeout), 32'd0);
    chk({tag, "_drain_timeout_4"}, 32'(drain_timeout_4), 32'd0);
  endtask

  // Exception with no pending bus traffic and fetch ready: minimum latency.
  task automatic run_exc(input exc_code_t code, input logic [31:0] pc, input logic bd,
                         input logic [31:0] bva, input logic [31:0] exp_epc,
                         input logic exp_bwe);
    int c;
    c = cyc;
    exc_valid = 1'b1;
    exc_code = code;
    exc_pc = pc;
    exc_in_delay_slot = bd;
    exc_badvaddr = bva;
    push_exc(c + 1, exp_epc, code, bd, exp_bwe, exp_bwe ? bva : 32'd0);
    push_rdr(c + 2, 32'hBFC0_0380);
    #1;
    chk("flush_capture", 32'(flush), 32'd1);
    chk("busy_capture", 32'(busy), 32'd0);
    tick();
    exc_valid = 1'b0;
    chk("busy_commit", 32'(busy), 32'd1);
    tick();
    tick();
    chk("busy_after_accept", 32'(busy), 32'd0);
    chk("redirect_pc_idle", redirect_pc, 32'd0);
  endtask

  initial begin
    int c;
    reset = 1'b1;
    exc_valid = 1'b0;
    exc_code = EXC_INT;
    exc_pc = 32'd0;
    exc_in_delay_slot = 1'b0;
    exc_badvaddr = 32'd0;
    is_eret = 1'b0;
    cp0_epc = 32'd0;
    mem_pending = 1'b0;
    redirect_ready = 1'b1;
    #2;
    reset_checks("por");
    tick();
    tick();
    reset = 1'b0;
    tick();

    // SYS, no delay slot.
    run_exc(EXC_SYS, 32'h8000_1000, 1'b0, 32'd0, 32'h8000_1000, 1'b0);
    // ADEL in a delay slot.
    run_exc(EXC_ADEL, 32'h8000_2004, 1'b1, 32'h0000_0003, 32'h8000_2000, 1'b1);

    // ERET with fetch stalling four redirect cycles.
    c = cyc;
    is_eret = 1'b1;
    cp0_epc = 32'h8000_3000;
    redirect_ready = 1'b0;
    push_eret(c + 1);
    push_rdr(c + 6, 32'h8000_3000);
    tick();
    is_eret = 1'b0;
    cp0_epc = 32'h1234_5678;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("eret_hold_valid", 32'(redirect_valid), 32'd1);
      chk("eret_hold_pc", redirect_pc, 32'h8000_3000);
      tick();
    end
    redirect_ready = 1'b1;
    chk("eret_last_valid", 32'(redirect_valid), 32'd1);
    tick();
    chk("eret_idle_busy", 32'(busy), 32'd0);
    chk("eret_idle_valid", 32'(redirect_valid), 32'd0);

    // OV with ten cycles of bus traffic outstanding.
    c = cyc;
    exc_valid = 1'b1;
    exc_code = EXC_OV;
    exc_pc = 32'h8000_4000;
    exc_in_delay_slot = 1'b0;
    exc_badvaddr = 32'h0000_DEAD;
    mem_pending = 1'b1;
    push_exc(c + 11, 32'h8000_4000, EXC_OV, 1'b0, 1'b0, 32'd0);
    push_rdr(c + 12, 32'hBFC0_0380);
    tick();
    exc_valid = 1'b0;
    repeat (8) tick();
    chk("drain_flush", 32'(flush), 32'd1);
    chk("drain_busy", 32'(busy), 32'd1);
    chk("drain_no_commit", 32'(cp0_exc_we), 32'd0);
    tick();
    mem_pending = 1'b0;
    tick();
    tick();
    chk("ov_no_timeout", 32'(drain_timeout), 32'd0);
    tick();
    chk("ov_idle_busy", 32'(busy), 32'd0);

    // Clear the sticky flag the DRAIN_MAX=4 instance set above.
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    reset_checks("rst_mid");
    tick();
    reset = 1'b0;
    tick();

    // Bus stuck: the DRAIN_MAX=4 instance must time out after four cycles.
    c = cyc;
    exc_valid = 1'b1;
    exc_code = EXC_BP;
    exc_pc = 32'h8000_5000;
    exc_in_delay_slot = 1'b0;
    exc_badvaddr = 32'd0;
    mem_pending = 1'b1;
    push_exc(c + 9, 32'h8000_5000, EXC_BP, 1'b0, 1'b0, 32'd0);
    push_rdr(c + 10, 32'hBFC0_0380);
    tick();
    exc_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("t4_no_commit_yet", 32'(cp0_exc_we_4), 32'd0);
    chk("t4_timeout_not_yet", 32'(drain_timeout_4), 32'd0);
    tick();
    chk("t4_commit", 32'(cp0_exc_we_4), 32'd1);
    chk("t4_timeout_set", 32'(drain_timeout_4), 32'd1);
    chk("t4_main_still_busy", 32'(busy), 32'd1);
    tick();
    tick();
    tick();
    mem_pending = 1'b0;
    tick();
    tick();
    chk("main_no_timeout", 32'(drain_timeout), 32'd0);
    tick();
    chk("bp_idle_busy", 32'(busy), 32'd0);
    chk("t4_timeout_sticky", 32'(drain_timeout_4), 32'd1);

    // Exception and ERET together; reset lands during REDIRECT.
    c = cyc;
    exc_valid = 1'b1;
    exc_code = EXC_RI;
    exc_pc = 32'h8000_6000;
    exc_in_delay_slot = 1'b0;
    is_eret = 1'b1;
    cp0_epc = 32'h8000_7000;
    redirect_ready = 1'b0;
    push_exc(c + 1, 32'h8000_6000, EXC_RI, 1'b0, 1'b0, 32'd0);
    tick();
    exc_valid = 1'b0;
    is_eret = 1'b0;
    tick();
    chk("both_redirect_valid", 32'(redirect_valid), 32'd1);
    chk("both_redirect_pc", redirect_pc, 32'hBFC0_0380);
    chk("t4_timeout_still_set", 32'(drain_timeout_4), 32'd1);
    tick();
    chk("both_hold_valid", 32'(redirect_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    reset_checks("rst_redirect");
    tick();
    reset = 1'b0;
    redirect_ready = 1'b1;
    tick();

    // Back from reset in IDLE; delay-slot wrap at pc 0 and an INT.
    run_exc(EXC_ADES, 32'h0000_0000, 1'b1, 32'h0000_0001, 32'hFFFF_FFFC, 1'b1);
    run_exc(EXC_INT, 32'h8000_8000, 1'b0, 32'h0000_0ABC, 32'h8000_8000, 1'b0);

    for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exc_redirect_ctrl.md
# exc_redirect_ctrl

Sequencer that acts on the combinational exception decision and on ERET requests. It captures the request, waits for outstanding data-bus transactions to drain, commits the CP0 state update in one cycle, then holds a PC redirect to fetch until fetch accepts it. It sits between the exception unit / commit stage and CP0, fetch and the hazard unit, and owns the pipeline flush and stall for the whole sequence.

## Interface
Parameters:
- EXC_ENTRY, 32'hBFC0_0380, redirect target for every exception (shared-package constant).
- DRAIN_MAX, 255, maximum cycles spent in DRAIN before forcing progress.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- exc_valid  in  1  exception decided this cycle.
- exc_code  in  5  exc_code_t (INT, ADEL, ADES, OV, SYS, BP, RI).
- exc_pc  in  32  PC of the excepting instruction.
- exc_in_delay_slot  in  1  excepting instruction is in a delay slot.
- exc_badvaddr  in  32  faulting address.
- is_eret  in  1  ERET committing this cycle.
- cp0_epc  in  32  current EPC, used as the ERET target.
- mem_pending  in  1  data bus has an outstanding transaction.
- redirect_ready  in  1  fetch accepts the redirect.
- busy  out  1  controller not IDLE; hazard stalls the pipeline.
- flush  out  1  kill all instructions younger than the capture point.
- cp0_exc_we  out  1  one-cycle pulse: write EPC, Cause.ExcCode and Cause.BD, set Status.EXL.
- cp0_epc_wdata  out  32  EPC value to write.
- cp0_exccode  out  5  Cause.ExcCode.
- cp0_bd  out  1  Cause.BD.
- cp0_badvaddr_we  out  1  one-cycle pulse: write BadVAddr.
- cp0_badvaddr  out  32  BadVAddr value.
- cp0_eret_clr  out  1  one-cycle pulse: clear Status.EXL.
- redirect_valid  out  1  redirect request to fetch.
- redirect_pc  out  32  redirect target.
- drain_timeout  out  1  sticky flag: DRAIN was exited by the timeout.

## Operation
- FSM states: IDLE, DRAIN, COMMIT, REDIRECT.
- **IDLE capture:**
  - If exc_valid=1, latch code, pc, bd and badvaddr, set kind=EXC, and set target=EXC_ENTRY.
  - Else if is_eret=1, set kind=ERET and target=cp0_epc.
  - If exc_valid and is_eret are high together, the exception wins and the ERET is dropped.
  - From IDLE, go to DRAIN if mem_pending=1, otherwise go to COMMIT.
- **DRAIN:** the counter increments each cycle. Exit to COMMIT when mem_pending=0, or when the counter reaches DRAIN_MAX; on timeout also set drain_timeout.
- **COMMIT (exactly 1 cycle):**
  - kind=EXC: pulse cp0_exc_we.
    - EPC = pc−4 when bd=1, else pc (32-bit modular; pc=0 with bd=1 gives 32'hFFFF_FFFC).
    - cp0_badvaddr_we is pulsed only for ADEL or ADES.
  - kind=ERET: pulse cp0_eret_clr only.
  - Next state is REDIRECT.
- **REDIRECT:** redirect_valid=1 and redirect_pc=target, held stable until redirect_ready=1. The cycle after acceptance, the FSM is back in IDLE.
- Requests arriving while busy=1 are ignored; the pipeline is frozen by busy, so the exception unit re-presents them afterwards.
- drain_timeout is cleared only by reset.

## Timing
- **Reset (asynchronous):** state=IDLE, counter=0, all latched fields 0, and every output 0, including drain_timeout.
- **busy** is registered: it is high from the cycle after capture until the cycle after redirect acceptance.
- **flush:** combinational. High in the capture cycle (IDLE with a request present), and in every non-IDLE state.
- **Minimum latency** (no pending transaction, redirect_ready already high):
  - capture in cycle 0;
  - COMMIT in cycle 1;
  - REDIRECT, accepted, in cycle 2;
  - IDLE in cycle 3.
- The cp0_* pulses are combinational decodes of state==COMMIT; they are never asserted in any other state.
- The DRAIN counter is 8 bits, reset on entry to DRAIN, and saturates at DRAIN_MAX.
- redirect_pc and the CP0 data outputs are driven from registers and are 0 whenever they are not in use.

## Structure
- Shared package (exception_pkg):
  - the state enum `exc_ctrl_state_t`;
  - the kind enum `exc_kind_t` {EXC, ERET};
  - the EXC_ENTRY constant;
  - the existing exc_code_t codes.
- Single module; no sub-module is needed. The FSM, counter and capture registers live in one always_ff, and the output decode in one always_comb.

## Test plan
- **SYS at pc=0x8000_1000, bd=0, mem_pending=0, ready=1** -> cycle 1: cp0_exc_we=1, epc=0x8000_1000, exccode=SYS, badvaddr_we=0. Cycle 2: redirect_pc=0xBFC0_0380. Cycle 3: busy=0.
- **ADEL with bd=1, pc=0x8000_2004, badvaddr=0x0000_0003** -> epc=0x8000_2000, bd=1, badvaddr_we=1 with 0x0000_0003.
- **ERET with cp0_epc=0x8000_3000; ready low 4 cycles then high** -> cp0_eret_clr pulses once. redirect_valid is held 5 cycles with a stable pc, then the FSM returns to IDLE.
- **OV with mem_pending high 10 cycles** -> DRAIN lasts 10 cycles, COMMIT follows, drain_timeout stays 0.
- **mem_pending stuck high, DRAIN_MAX=4** -> COMMIT after 4 DRAIN cycles and drain_timeout=1; it stays 1 until reset.
- **exc_valid and is_eret together, then reset asserted during REDIRECT** -> an exception sequence runs with no cp0_eret_clr. After reset, all outputs are 0 immediately and state is IDLE.
